// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Iterative restoring divider for unsigned operands. Each clock in RUN
// resolves one quotient bit, so a division takes DW clocks. A divisor of zero
// bypasses the iteration and reports dbz with a saturated quotient.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   start      in   1   divide request, accepted in IDLE or DONE
//   dividend   in   DW  numerator, latched on an accepted start
//   divisor    in   VW  denominator, latched on an accepted start
//   busy       out  1   iteration in progress (state RUN)
//   done       out  1   one-cycle pulse when results update (state DONE)
//   quotient   out  DW  registered quotient, held until the next done
//   remainder  out  VW  registered remainder, held until the next done
//   dbz        out  1   current result came from a divide by zero
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q,     state_d;
    logic [VW-1:0] divisor_q,   divisor_d;
    logic [DW-1:0] work_q,      work_d;       // dividend shifting out, quotient shifting in
    logic [VW:0]   prem_q,      prem_d;       // partial remainder, one guard bit
    logic [CW-1:0] count_q,     count_d;
    logic [DW-1:0] quotient_q,  quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          dbz_q,       dbz_d;

    // Restoring step datapath. The partial remainder is always below the
    // divisor, so the top bit of 'shifted' is zero and the MSB of 'trial'
    // is a pure borrow: set means the subtraction went negative.
    logic [VW+1:0] shifted;
    logic [VW+1:0] trial;
    logic          trial_ok;
    logic [VW:0]   step_rem;
    logic [DW-1:0] step_quo;

    always_comb begin
        shifted  = {prem_q, work_q[DW-1]};
        trial    = shifted - {2'b00, divisor_q};
        trial_ok = ~trial[VW+1];
        step_rem = trial_ok ? trial[VW:0] : shifted[VW:0];
        step_quo = {work_q[DW-2:0], trial_ok};
    end

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        divisor_d   = divisor_q;
        work_d      = work_q;
        prem_d      = prem_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    divisor_d = divisor;
                    work_d    = dividend;
                    prem_d    = '0;
                    if (divisor == '0) begin
                        // Results are published immediately; RUN is skipped.
                        quotient_d  = '1;
                        remainder_d = dividend[VW-1:0];
                        dbz_d       = 1'b1;
                        count_d     = '0;
                        state_d     = DONE;
                    end else begin
                        count_d = CW'(DW - 1);
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                prem_d = step_rem;
                work_d = step_quo;
                if (count_q == '0) begin
                    quotient_d  = step_quo;
                    remainder_d = step_rem[VW-1:0];
                    dbz_d       = 1'b0;
                    state_d     = DONE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of order.
    // NOTE: all registers here are plain flops, so each one is reset; there
    // is no memory array that would need to be left out of the reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            divisor_q   <= '0;
            work_q      <= '0;
            prem_q      <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            divisor_q   <= divisor_d;
            work_q      <= work_d;
            prem_q      <= prem_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//
// Directed and random stimulus for seq_divider. Expected results are computed
// by a behavioural model when a start is driven, queued, and compared when
// the divider pulses done. Inputs change and outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          dbz;

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dbz;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a[VW-1:0];
            e.dbz = 1'b1;
        end else begin
            e.q   = DW'(int'(a) / int'(b));
            e.r   = VW'(int'(a) % int'(b));
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic compare_result(input string tag);
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e = '0;
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end
        check({tag, "_q"},   quotient,  e.q);
        check({tag, "_r"},   remainder, e.r);
        check({tag, "_dbz"}, dbz,       e.dbz);
        last_exp = e;
    endtask

    // One operation: start pulsed for a single edge. glitch_at >= 0 re-asserts
    // start with 9/3 for one cycle that many cycles into the run.
    task automatic run_op(input string tag, input logic [DW-1:0] a,
                          input logic [VW-1:0] b, input int glitch_at);
        int idx;
        int bc;
        int lat;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
        idx   = 0;
        bc    = 0;
        while (done !== 1'b1 && idx < 40) begin
            if (idx == glitch_at) begin
                dividend = 8'd9;
                divisor  = 4'd3;
                start    = 1'b1;
            end else if (idx == glitch_at + 1) begin
                start = 1'b0;
            end
            if (idx == 4) begin
                check({tag, "_hold_q"},   quotient,  last_exp.q);
                check({tag, "_hold_r"},   remainder, last_exp.r);
                check({tag, "_hold_dbz"}, dbz,       last_exp.dbz);
            end
            bc += int'(busy === 1'b1);
            idx++;
            @(negedge clk);
        end
        start = 1'b0;
        lat   = (b == '0) ? 0 : DW;
        check({tag, "_done_seen"},   done, 1);
        check({tag, "_done_lat"},    idx,  lat);
        check({tag, "_busy_cycles"}, bc,   lat);
        compare_result(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle_busy"},  busy, 0);
    endtask

    initial begin
        int seen;
        int idx;
        logic [DW-1:0] ra;
        logic [VW-1:0] rb;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        last_exp = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", busy,      0);
        check("rst_done", done,      0);
        check("rst_q",    quotient,  0);
        check("rst_r",    remainder, 0);
        check("rst_dbz",  dbz,       0);
        rst = 1'b0;

        // Reset in the middle of 200/7 aborts with no done.
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy_before", busy, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy_async", busy, 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            seen += int'(done === 1'b1);
        end
        check("abort_no_done", seen,      0);
        check("abort_q",       quotient,  0);
        check("abort_r",       remainder, 0);
        check("abort_dbz",     dbz,       0);
        last_exp = '0;

        // Directed operations and boundaries.
        run_op("d225_15", 8'd225, 4'd15, -1);
        run_op("d200_7",  8'd200, 4'd7,  -1);
        run_op("d5_9",    8'd5,   4'd9,  -1);
        run_op("d255_1",  8'd255, 4'd1,  -1);
        run_op("d255_15", 8'd255, 4'd15, -1);
        run_op("d254_15", 8'd254, 4'd15, -1);
        run_op("d60_0",   8'd60,  4'd0,  -1);

        // Start re-asserted mid-run is ignored.
        run_op("glitch",  8'd200, 4'd7,  3);

        // Start held high: one result every DW+1 cycles.
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 4'd10;
        start    = 1'b1;
        sb.push_back(model(8'd100, 4'd10));
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            idx = 0;
            while (done !== 1'b1 && idx < 40) begin
                idx++;
                @(negedge clk);
            end
            check("b2b_done_seen", done, 1);
            check("b2b_period",    idx,  DW);
            compare_result("b2b");
            if (n < 2) begin
                sb.push_back(model(8'd100, 4'd10));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_stop_done", done, 0);
        check("b2b_stop_busy", busy, 0);

        // Random sweep against the model.
        for (int i = 0; i < 2000; i++) begin
            ra = DW'($urandom_range(0, 255));
            rb = VW'($urandom_range(0, 15));
            run_op("rand", ra, rb, -1);
        end

        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring divider: the inverse operation of the registered 4x4 multiplier in the same tile.
- Takes an 8-bit dividend and a 4-bit divisor; returns an 8-bit quotient and a 4-bit remainder.
- Resolves one quotient bit per clock, so throughput is traded for area.
- Sits behind the tile's pin mapping: ui_in carries the dividend, uio_in[3:0] carries the divisor, and the results and status drive uo_out/uio_out.

Parameters:
- DW, 8, dividend and quotient width; also the number of iterations.
- VW, 4, divisor and remainder width; must satisfy VW <= DW.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to divide; sampled on the rising edge of clk.
- dividend  input  DW  numerator, latched on an accepted start.
- divisor  input  VW  denominator, latched on an accepted start.
- busy  output  1  high while an iteration is in progress.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  DW  registered result.
- remainder  output  VW  registered result.
- dbz  output  1  divide-by-zero flag for the current result.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - busy, done, dbz, quotient and remainder all clear to 0.
  - Internal operand, partial-remainder and counter registers clear.
  - A reset during RUN aborts the operation; no done is produced.
- FSM states: IDLE, RUN, DONE.
  - busy = (state == RUN).
  - done = (state == DONE).
- Start acceptance:
  - start is accepted only on an edge where state is IDLE or DONE.
  - start while busy=1 is ignored and not queued.
  - An accepted start latches dividend and divisor.
- Normal start (divisor != 0):
  - Load the working quotient register with the dividend.
  - Clear the partial remainder. It is VW+1 bits wide so the trial subtraction never overflows.
  - Set iteration count to DW-1 and go to RUN.
- Each RUN edge (restoring step):
  - Shift {partial remainder, working quotient} left by 1.
  - Trial: t = shifted partial remainder - {1'b0, divisor}.
  - If t is non-negative: partial remainder <= t, new quotient LSB = 1.
  - Otherwise: keep the shifted partial remainder, new quotient LSB = 0.
  - When count reaches 0, the same edge also updates quotient, remainder[VW-1:0] and dbz=0, and moves the FSM to DONE.
- Latency, counting the accepting edge as edge 0:
  - busy is high after edge 0 through edge DW-1.
  - done is high for exactly the cycle following edge DW.
  - DONE goes to IDLE on the next edge, unless a new start is accepted there, in which case it goes to RUN.
- Divide by zero (accepted start with divisor == 0):
  - Skip RUN and go directly to DONE.
  - quotient <= all ones, remainder <= dividend[VW-1:0], dbz <= 1.
  - done pulses in the cycle after the start edge; busy never rises.
- Result hold: quotient, remainder and dbz hold their value until the next done. Starting a new operation does not clear them.
- Back-to-back operation: start held high continuously gives one operation every DW+1 cycles, because the DONE cycle re-accepts start.
- Arithmetic: all operands are unsigned. Invariant: dividend = quotient*divisor + remainder, with remainder < divisor.

Test Plan:
- Reset mid-run:
  - Hold rst=1 → all outputs 0.
  - Start 200/7, assert rst 3 cycles later → busy drops immediately (async), done never pulses, and outputs stay 0.
- 225/15 → quotient=15, remainder=0, dbz=0.
  - busy is high for exactly 8 cycles; done pulses once, 8 edges after the start edge.
  - 200/7 then gives quotient=28, remainder=4.
- Boundaries:
  - 5/9 → quotient=0, remainder=5.
  - 255/1 → quotient=255, remainder=0.
  - 255/15 → quotient=17, remainder=0.
  - 254/15 → quotient=16, remainder=14.
- Divide by zero: 60/0 → dbz=1, quotient=255, remainder=12; done in the cycle after start; busy stays 0.
- Start while busy:
  - Re-assert start with 9/3 mid-run of 200/7 → ignored, and the result is still 28 r 4.
  - Start held high continuously with 100/10 → done every 9 cycles, quotient=10, remainder=0.
- Random sweep: 2000 random pairs checked against a reference model → the quotient and remainder invariant holds. Results are stable between done pulses.
